button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, meaning consecutive stable cycles required before a level change is accepted (10 ms at 100 MHz); legal range >= 2.
REQ-002 CLK  input  1  system clock, all state on rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW  input  1 each  raw, asynchronous push-button levels.
REQ-005 PAUSE_RAW  input  1  raw, asynchronous slide-switch level.
REQ-006 BTNU, BTND, BTNL, BTNR  output  1 each  debounced button levels.
REQ-007 PAUSE  output  1  debounced pause level.
REQ-008 BTN_PRESS  output  4  one-cycle press pulses; bit3=U, bit2=D, bit1=L, bit0=R.
REQ-009 DIR_VALID  output  1  one-cycle strobe marking a new direction request.
REQ-010 DIR_CODE  output  2  direction of the current DIR_VALID: 00 up, 01 right, 10 down, 11 left; holds its value between strobes.

Function
REQ-011 Each of the five raw inputs SHALL pass through its own two-flop synchroniser before any other logic.
REQ-012 Each channel SHALL hold a stable level and a counter of width $clog2(DEBOUNCE_CYCLES).
REQ-013 While the synchronised level equals the stable level, the counter SHALL be 0.
REQ-014 While the synchronised level differs from the stable level, the counter SHALL increment once per cycle.
REQ-015 On the cycle the counter equals DEBOUNCE_CYCLES-1 with the levels still differing, the stable level SHALL take the synchronised value and the counter SHALL clear.
REQ-016 Any glitch returning to the stable level before acceptance SHALL clear the counter; no partial credit is kept.
REQ-017 Latency from a clean raw edge to the stable-level change SHALL be exactly 2+DEBOUNCE_CYCLES clock edges.
REQ-018 BTN_PRESS[i] SHALL be high for exactly the first cycle in which the stable level of button i is 1; release SHALL produce no pulse.
REQ-019 DIR_VALID SHALL be registered and high the cycle after any BTN_PRESS bit is high; DIR_CODE SHALL update on that same edge.
REQ-020 Simultaneous BTN_PRESS bits SHALL resolve with priority U > R > D > L; lower-priority presses in that cycle SHALL be discarded, not queued.
REQ-021 PAUSE SHALL produce no pulse or direction output, level only.
REQ-022 Channels SHALL be fully independent; activity on one SHALL NOT affect the counter of another.

Reset
REQ-023 Asserting RESET low SHALL immediately clear all synchroniser flops, stable levels, counters, BTN_PRESS, DIR_VALID and PAUSE to 0, and set DIR_CODE to 00.
REQ-024 A button held through reset release SHALL be accepted as a new press after 2+DEBOUNCE_CYCLES cycles, generating BTN_PRESS and DIR_VALID.
REQ-025 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for that edge.

Structure
REQ-026 Direction code constants (UP, RIGHT, DOWN, LEFT) and the default DEBOUNCE_CYCLES SHALL live in the shared game package used by the navigation state machine.
REQ-027 One sub-module, debounce_channel (synchroniser + counter + stable level + rising pulse), SHALL be instantiated five times.
REQ-028 The priority encoder and the DIR registers SHALL reside in button_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Clean BTNU_RAW 0->1 at edge 0 -> BTNU=1 and BTN_PRESS=1000 after edge 6; DIR_VALID=1, DIR_CODE=00 after edge 7; both pulses 1 cycle wide.
REQ-030 BTNL_RAW high for 3 cycles then low -> BTNL, BTN_PRESS and DIR_VALID stay 0 throughout.
REQ-031 BTND_RAW and BTNR_RAW rise on the same edge -> BTN_PRESS=0101 for one cycle; one DIR_VALID with DIR_CODE=01; no later strobe for down.
REQ-032 RESET low for 1 cycle while BTNR_RAW has been high for 3 cycles -> outputs 0 immediately; press accepted 6 edges after release, DIR_CODE=01.
REQ-033 PAUSE_RAW toggling every cycle for 20 cycles, then high -> PAUSE=0 during toggling; PAUSE=1 exactly 6 edges after final rise; DIR_VALID never asserts.
REQ-034 BTNU held 50 cycles then released -> exactly one BTN_PRESS and one DIR_VALID; BTNU returns to 0 six edges after release.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_conditioner_pkg
// Shared game package: direction codes understood by the navigation state
// machine, the default debounce length, the bit positions of the four
// buttons inside the BTN_PRESS vector, and the priority encoder that turns
// simultaneous presses into a single direction.
// ---------------------------------------------------------------------------
package button_conditioner_pkg;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    UP    = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    LEFT  = 2'b11
  } dir_e;

  // Bit positions inside BTN_PRESS
  localparam int BTN_U = 3;
  localparam int BTN_D = 2;
  localparam int BTN_L = 1;
  localparam int BTN_R = 0;

  // Up beats right beats down beats left; losers in the same cycle are dropped.
  function automatic dir_e encode_dir(input logic [3:0] press);
    dir_e dir;
    if (press[BTN_U])      dir = UP;
    else if (press[BTN_R]) dir = RIGHT;
    else if (press[BTN_D]) dir = DOWN;
    else                   dir = LEFT;
    return dir;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
// One input channel: two-flop synchroniser, consecutive-cycle stability
// counter, accepted (stable) level and a one-cycle pulse on acceptance of a
// rising level.
//
// Ports
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset
//   raw    in   raw asynchronous level
//   level  out  debounced level
//   press  out  high for the first cycle the debounced level is 1
// ---------------------------------------------------------------------------
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] cnt_p2;
  logic             stable_p2;
  logic             press_p2;
  logic             differ;
  logic             accept;

  // Stage 0/1: metastability filter on the raw pin
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // The counter holds (number of consecutive differing cycles - 1), so the
  // change is accepted on the DEBOUNCE_CYCLES-th differing cycle.
  always_comb begin
    differ = (sync_p1 != stable_p2);
    accept = differ && (cnt_p2 == CNT_LAST);
  end

  // Stage 2: stability counter, accepted level and rising pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p2    <= '0;
      stable_p2 <= 1'b0;
      press_p2  <= 1'b0;
    end else begin
      press_p2 <= accept && sync_p1;
      if (!differ || accept) begin
        cnt_p2 <= '0;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
      if (accept) begin
        stable_p2 <= sync_p1;
      end
    end
  end

  assign level = stable_p2;
  assign press = press_p2;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
// Debounces four push buttons and a pause slide switch, emits one-cycle
// press pulses and converts them into a registered direction request.
//
// Ports
//   CLK        in   system clock
//   RESET      in   asynchronous active-low reset
//   BTNx_RAW   in   raw button levels (U, D, L, R)
//   PAUSE_RAW  in   raw slide-switch level
//   BTNx       out  debounced button levels
//   PAUSE      out  debounced pause level (no pulse, no direction)
//   BTN_PRESS  out  press pulses {U, D, L, R}
//   DIR_VALID  out  one-cycle strobe, one cycle after any press pulse
//   DIR_CODE   out  direction of the latest strobe, held between strobes
// ---------------------------------------------------------------------------
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       BTNU_RAW,
  input  logic       BTND_RAW,
  input  logic       BTNL_RAW,
  input  logic       BTNR_RAW,
  input  logic       PAUSE_RAW,
  output logic       BTNU,
  output logic       BTND,
  output logic       BTNL,
  output logic       BTNR,
  output logic       PAUSE,
  output logic [3:0] BTN_PRESS,
  output logic       DIR_VALID,
  output logic [1:0] DIR_CODE
);

  logic [3:0] btn_raw;
  logic [3:0] btn_level;
  logic [3:0] press_p2;
  logic       pause_press_unused;
  logic       dir_vld_p3;
  dir_e       dir_code_p3;

  assign btn_raw[BTN_U] = BTNU_RAW;
  assign btn_raw[BTN_D] = BTND_RAW;
  assign btn_raw[BTN_L] = BTNL_RAW;
  assign btn_raw[BTN_R] = BTNR_RAW;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_channel (
      .clk  (CLK),
      .rst_n(RESET),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(press_p2[i])
    );
  end

  // The pause switch is level-only; its pulse is deliberately left unused.
  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_pause (
    .clk  (CLK),
    .rst_n(RESET),
    .raw  (PAUSE_RAW),
    .level(PAUSE),
    .press(pause_press_unused)
  );

  // Stage 3: direction request register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      dir_vld_p3  <= 1'b0;
      dir_code_p3 <= UP;
    end else begin
      dir_vld_p3 <= |press_p2;
      if (|press_p2) begin
        dir_code_p3 <= encode_dir(press_p2);
      end
    end
  end

  assign BTNU      = btn_level[BTN_U];
  assign BTND      = btn_level[BTN_D];
  assign BTNL      = btn_level[BTN_L];
  assign BTNR      = btn_level[BTN_R];
  assign BTN_PRESS = press_p2;
  assign DIR_VALID = dir_vld_p3;
  assign DIR_CODE  = dir_code_p3;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
// Directed scenarios with literal timing expectations plus a randomized run,
// every cycle compared against a window-based behavioural model: a level is
// accepted once the last DEBOUNCE_CYCLES synchronised samples all disagree
// with the current accepted level.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N     = 4;
  localparam int DEPTH = N + 2;  // 2 synchroniser delays + N-sample window

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       BTNU_RAW = 1'b0;
  logic       BTND_RAW = 1'b0;
  logic       BTNL_RAW = 1'b0;
  logic       BTNR_RAW = 1'b0;
  logic       PAUSE_RAW = 1'b0;
  logic       BTNU, BTND, BTNL, BTNR, PAUSE;
  logic [3:0] BTN_PRESS;
  logic       DIR_VALID;
  logic [1:0] DIR_CODE;

  int checks = 0;
  int errors = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(N)) dut (
    .CLK(CLK), .RESET(RESET),
    .BTNU_RAW(BTNU_RAW), .BTND_RAW(BTND_RAW), .BTNL_RAW(BTNL_RAW),
    .BTNR_RAW(BTNR_RAW), .PAUSE_RAW(PAUSE_RAW),
    .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR), .PAUSE(PAUSE),
    .BTN_PRESS(BTN_PRESS), .DIR_VALID(DIR_VALID), .DIR_CODE(DIR_CODE)
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // channel index: 4 = pause, 3 = U, 2 = D, 1 = L, 0 = R
  typedef struct packed {
    logic [4:0][DEPTH-1:0] hist;   // hist[c][k] = raw sampled k edges ago
    logic [4:0]            stable;
    logic [3:0]            press;
    logic                  dir_valid;
    logic [1:0]            dir_code;
  } mstate_t;

  // priority list U, R, D, L; direction code equals position in the list
  localparam int PRIO_BIT [4] = '{3, 0, 2, 1};

  logic [4:0] raw_v;
  assign raw_v = {PAUSE_RAW, BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW};

  function automatic mstate_t model_step(input mstate_t s, input logic [4:0] raw);
    mstate_t n;
    logic found;
    logic all_flip;
    n = s;
    found = 1'b0;
    n.dir_valid = |s.press;
    for (int p = 0; p < 4; p++) begin
      if (!found && s.press[PRIO_BIT[p]]) begin
        n.dir_code = 2'(p);
        found = 1'b1;
      end
    end
    n.press = '0;
    for (int c = 0; c < 5; c++) begin
      n.hist[c] = {s.hist[c][DEPTH-2:0], raw[c]};
      all_flip = 1'b1;
      for (int j = 2; j < DEPTH; j++) begin
        if (n.hist[c][j] == s.stable[c]) all_flip = 1'b0;
      end
      if (all_flip) begin
        n.stable[c] = ~s.stable[c];
        if (c < 4 && n.stable[c]) n.press[c] = 1'b1;
      end
    end
    return n;
  endfunction

  mstate_t m;
  always @(posedge CLK or negedge RESET) begin
    if (!RESET) m <= '0;
    else        m <= model_step(m, raw_v);
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    check("model_btnu",  32'(BTNU),      32'(m.stable[3]));
    check("model_btnd",  32'(BTND),      32'(m.stable[2]));
    check("model_btnl",  32'(BTNL),      32'(m.stable[1]));
    check("model_btnr",  32'(BTNR),      32'(m.stable[0]));
    check("model_pause", 32'(PAUSE),     32'(m.stable[4]));
    check("model_press", 32'(BTN_PRESS), 32'(m.press));
    check("model_valid", 32'(DIR_VALID), 32'(m.dir_valid));
    check("model_code",  32'(DIR_CODE),  32'(m.dir_code));
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
    compare_model();
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_levels"}, 32'({BTNU, BTND, BTNL, BTNR, PAUSE}), 32'd0);
    check({name, "_press"},  32'(BTN_PRESS), 32'd0);
    check({name, "_valid"},  32'(DIR_VALID), 32'd0);
    check({name, "_code"},   32'(DIR_CODE),  32'd0);
  endtask

  initial begin
    int n_press;
    int n_valid;
    logic [4:0] r;
    logic p;

    // reset state
    tick();
    tick();
    check_all_zero("reset");
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) tick();

    // clean up-press held 50 cycles, then released
    n_press = 0;
    n_valid = 0;
    BTNU_RAW = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      tick();
      check("up_level", 32'(BTNU), 32'(t >= 6));
      check("up_press", 32'(BTN_PRESS), (t == 6) ? 32'h8 : 32'h0);
      check("up_valid", 32'(DIR_VALID), 32'(t == 7));
      check("up_code", 32'(DIR_CODE), 32'd0);
      if (t == 6) check("model_pin_up", 32'({m.stable[3], m.press}), 32'h18);
      n_press += int'(|BTN_PRESS);
      n_valid += int'(DIR_VALID);
    end
    BTNU_RAW = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check("up_release_level", 32'(BTNU), 32'(t < 6));
      n_press += int'(|BTN_PRESS);
      n_valid += int'(DIR_VALID);
    end
    check("up_press_count", 32'(n_press), 32'd1);
    check("up_valid_count", 32'(n_valid), 32'd1);

    // left glitch of 3 cycles is never accepted
    BTNL_RAW = 1'b1;
    for (int t = 1; t <= 12; t++) begin
      if (t == 4) BTNL_RAW = 1'b0;
      tick();
      check("glitch_level", 32'(BTNL), 32'd0);
      check("glitch_press", 32'(BTN_PRESS), 32'd0);
      check("glitch_valid", 32'(DIR_VALID), 32'd0);
    end

    // simultaneous down + right: right wins, down discarded
    n_valid = 0;
    BTND_RAW = 1'b1;
    BTNR_RAW = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      check("dr_press", 32'(BTN_PRESS), (t == 6) ? 32'h5 : 32'h0);
      check("dr_valid", 32'(DIR_VALID), 32'(t == 7));
      check("dr_code", 32'(DIR_CODE), (t >= 7) ? 32'd1 : 32'd0);
      check("dr_levels", 32'({BTND, BTNR}), (t >= 6) ? 32'd3 : 32'd0);
      n_valid += int'(DIR_VALID);
    end
    check("dr_valid_count", 32'(n_valid), 32'd1);
    BTND_RAW = 1'b0;
    BTNR_RAW = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    // reset mid-count while right is held, then accepted after release
    BTNR_RAW = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    RESET = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("model_pin_reset", 32'(m), 32'd0);
    tick();
    RESET = 1'b1;
    for (int t = 1; t <= 8; t++) begin
      tick();
      check("rr_level", 32'(BTNR), 32'(t >= 6));
      check("rr_press", 32'(BTN_PRESS), (t == 6) ? 32'h1 : 32'h0);
      check("rr_valid", 32'(DIR_VALID), 32'(t == 7));
      check("rr_code", 32'(DIR_CODE), (t >= 7) ? 32'd1 : 32'd0);
    end
    BTNR_RAW = 1'b0;
    for (int i = 0; i < 8; i++) tick();

    // pause toggling every cycle, then held high
    p = 1'b0;
    for (int t = 1; t <= 20; t++) begin
      p = ~p;
      PAUSE_RAW = p;
      tick();
      check("pause_toggle", 32'(PAUSE), 32'd0);
      check("pause_no_dir", 32'(DIR_VALID), 32'd0);
    end
    PAUSE_RAW = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      tick();
      check("pause_level", 32'(PAUSE), 32'(t >= 6));
      check("pause_no_dir", 32'(DIR_VALID), 32'd0);
      check("pause_no_press", 32'(BTN_PRESS), 32'd0);
    end

    // randomized run with occasional asynchronous resets
    r = raw_v;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 5; c++) begin
        if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
      end
      {PAUSE_RAW, BTNU_RAW, BTND_RAW, BTNL_RAW, BTNR_RAW} = r;
      if ($urandom_range(0, 299) == 0) begin
        RESET = 1'b0;
        #1;
        check_all_zero("rand_reset");
        tick();
        RESET = 1'b1;
      end else begin
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
